// File: rtl/mem_bus_pkg.sv
// Shared constants, FSM state encoding and latched-request type for the
// memory responder and its storage.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Request fields kept after acceptance; the word index is held separately
  // because its width depends on the instance depth.
  typedef struct packed {
    logic              we;
    logic              err;
    logic [DATA_W-1:0] wdata;
  } req_lat_t;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port synchronous word RAM, registered read data, no reset.
// Read-before-write: dout shows the old word on a write cycle.
module word_ram
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int DW    = 32,
  parameter int AW    = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: valid/ready request, programmable
// wait states, one access cycle, then a held response until it is taken.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int                ADDR_W      = mem_bus_pkg::ADDR_W,
  parameter int                DATA_W      = mem_bus_pkg::DATA_W,
  parameter int                DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                IDX_W     = idx_w(DEPTH_WORDS);
  localparam logic [ADDR_W:0]   SPAN      = (ADDR_W+1)'(DEPTH_WORDS) << 2;
  localparam logic [3:0]        WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state;
  logic [3:0]        cnt;
  req_lat_t          req_q;
  logic [IDX_W-1:0]  idx_q;
  logic              rd_ok;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_we;

  // Decode on the live request; only the result is latched at acceptance.
  logic [ADDR_W-1:0] off;
  logic              dec_err;
  assign off     = req_addr - BASE_ADDR;
  assign dec_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                   ({1'b0, off} >= SPAN);

  // Gating with rst_n lets a reset at the edge leaving ACCESS cancel the write.
  assign ram_we = (state == ACCESS) && req_q.we && !req_q.err && rst_n;

  word_ram #(
    .DEPTH (DEPTH_WORDS),
    .DW    (DATA_W),
    .AW    (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (idx_q),
    .din  (req_q.wdata),
    .dout (ram_dout)
  );

  // RAM address is frozen through RESP, so its output register stays stable.
  assign rsp_rdata = rd_ok ? ram_dout : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_ok     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_q.we    <= req_we;
            req_q.err   <= dec_err;
            req_q.wdata <= req_wdata;
            idx_q       <= off[IDX_W+1:2];
            req_ready   <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= req_q.err;
          rd_ok     <= !req_q.we && !req_q.err;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_ok     <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
